busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction-fetch stage of the MIPS pipeline. It holds the program counter, drives the instruction-memory address, and registers the fetched word plus PC+4 into the IF/ID pipeline register. It selects the next PC among sequential, branch, jump and jump-register targets. It also exports the 28-bit jump field consumed by `soma_jump`, and accepts the jump address that block produces.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold PC and IF/ID (load-use hazard).
- `flush` input 1: squash the IF/ID contents on this edge.
- `sel_pc` input 2: next-PC source. 00 = PC+4, 01 = branch, 10 = jump, 11 = jr.
- `desvio_offset` input 32: sign-extended branch immediate, in words.
- `endereco_jump` input 32: jump address from `soma_jump`; only bits [27:0] are used.
- `registrador_jr` input 32: register-file value for jr.
- `instrucao_mem` input 32: instruction-memory read data. The read is combinational from `pc_saida`.
- `pc_saida` output 32: current PC, which is the instruction-memory address.
- `if_id_instrucao` output 32: registered instruction.
- `if_id_pc4` output 32: registered PC+4 of that instruction.
- `if_id_valido` output 1: the IF/ID contents are a real instruction.
- `campo_jump` output 28: `{if_id_instrucao[25:0], 2'b00}`, combinational; feeds `soma_jump`.
- `erro_alinhamento` output 1: sticky flag, set by a jr to an address not word-aligned.
- `contador_busca` output 32: count of instructions accepted into IF/ID.

## Operation
- **Priority on each edge:** `reset` > redirect (`sel_pc` ≠ 00) > `stall` > sequential.
- **Reset** sets these values on the edge:
  - `pc_saida` = `RESET_PC`
  - `if_id_instrucao` = 0
  - `if_id_pc4` = 0
  - `if_id_valido` = 0
  - `erro_alinhamento` = 0
  - `contador_busca` = 0
- **Next-PC targets.** Arithmetic is 32-bit and unsigned, wrapping modulo 2^32.
  - Sequential (00): `pc_saida` + 4.
  - Branch (01): `if_id_pc4` + (`desvio_offset` << 2). Bits shifted out of bit 31 are discarded.
  - Jump (10): `{if_id_pc4[31:28], endereco_jump[27:0]}`.
  - Jr (11): `{registrador_jr[31:2], 2'b00}`. If `registrador_jr[1:0]` ≠ 0, set `erro_alinhamento`. The flag stays set until reset.
- **Redirect** (`sel_pc` ≠ 00): PC loads the target, even when `stall` = 1.
- **Stall without redirect:** PC holds.
- **IF/ID register update:**
  - `flush` = 1 loads instruction 0 (NOP), `if_id_pc4` 0 and `if_id_valido` 0. Flush overrides stall.
  - Otherwise, `stall` = 1 holds all IF/ID contents.
  - Otherwise, the register loads `instrucao_mem`, `pc_saida` + 4 and `if_id_valido` = 1.
- **Counter:** `contador_busca` increments by 1 on each edge where IF/ID loads a valid instruction (no reset, no flush, no stall). It wraps at 2^32.
- **Delay slot:** the decode logic must assert `flush` together with any taken redirect. The block does not flush implicitly.

## Timing
- Fetch latency is one cycle: the word at `pc_saida` in cycle n appears on `if_id_instrucao` in cycle n+1.
- Redirect penalty is one cycle. The target is fetched in the cycle after `sel_pc` ≠ 00 is sampled.
- `campo_jump` follows `if_id_instrucao` combinationally. `soma_jump` output returns as `endereco_jump` within the same cycle.
- **Reset mid-stall or mid-redirect:** reset wins, and the next fetch is from `RESET_PC`.
- **Wrap:** a PC of 32'hFFFF_FFFC followed by a sequential step gives 32'h0000_0000, with no error.
- `stall` and `flush` asserted together: PC holds and IF/ID becomes a NOP. This is a legal bubble insertion.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `RESET_PC` = 0x0040_0000 → `pc_saida` = 0x0040_0000, `if_id_valido` = 0, `contador_busca` = 0.
- **Sequential fetch:** 4 cycles with memory returning 0x2001_0005, … → `pc_saida` steps +4 each cycle, `if_id_pc4` = 0x0040_0004 after the first edge, `contador_busca` = 4.
- **Stall:** `stall` = 1 for 2 cycles → `pc_saida` and `if_id_instrucao` unchanged, `contador_busca` unchanged. Release → the sequence resumes.
- **Jump:** `if_id_pc4` = 0x0040_0010, `endereco_jump` = 0x0000_0100, `sel_pc` = 10, `flush` = 1 → `pc_saida` = 0x0000_0100, `if_id_valido` = 0.
- **Branch backward:** `if_id_pc4` = 0x0040_0020, `desvio_offset` = 0xFFFF_FFFC → `pc_saida` = 0x0040_0010.
- **Jr and wrap:**
  - `registrador_jr` = 0x0000_1002 → `pc_saida` = 0x0000_1000 and `erro_alinhamento` = 1; the flag persists until reset.
  - A PC of 0xFFFF_FFFC followed by a sequential step → 0x0000_0000.

Source files
------------

// File: rtl/busca_instrucao.sv
// busca_instrucao: MIPS instruction-fetch stage. Holds the PC, addresses
// instruction memory, and registers the fetched word plus PC+4 into IF/ID.
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   stall, flush          - hold the stage / squash IF/ID to a NOP
//   sel_pc                - next PC: 00 seq, 01 branch, 10 jump, 11 jr
//   desvio_offset         - sign-extended branch offset in words
//   endereco_jump         - jump address from soma_jump (bits [27:0] used)
//   registrador_jr        - register value for jr
//   instrucao_mem         - combinational memory read data at pc_saida
//   pc_saida              - current PC / memory address
//   if_id_instrucao/pc4   - IF/ID instruction and its PC+4
//   if_id_valido          - IF/ID holds a real instruction
//   campo_jump            - {if_id_instrucao[25:0], 2'b00} for soma_jump
//   erro_alinhamento      - sticky flag for a misaligned jr target
//   contador_busca        - number of instructions accepted into IF/ID
module busca_instrucao #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  sel_pc,
    input  logic [31:0] desvio_offset,
    input  logic [31:0] endereco_jump,
    input  logic [31:0] registrador_jr,
    input  logic [31:0] instrucao_mem,
    output logic [31:0] pc_saida,
    output logic [31:0] if_id_instrucao,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valido,
    output logic [27:0] campo_jump,
    output logic        erro_alinhamento,
    output logic [31:0] contador_busca
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;
    logic [31:0] cont_q, cont_d;

    logic [31:0] pc_mais4;
    logic [31:0] desloc;
    logic [31:0] alvo;
    logic        redirect;
    logic        carrega;

    always_comb begin
        pc_mais4 = pc_q + 32'd4;
        // Full-width shift: bits leaving bit 31 are simply dropped.
        desloc   = desvio_offset << 2;
        alvo     = pc_mais4;
        erro_d   = erro_q;
        unique case (sel_pc)
            2'b00: alvo = pc_mais4;
            2'b01: alvo = pc4_q + desloc;
            2'b10: alvo = (pc4_q & 32'hF000_0000)
                        | (endereco_jump & 32'h0FFF_FFFF);
            2'b11: begin
                alvo = {registrador_jr[31:2], 2'b00};
                if (registrador_jr[1:0] != 2'b00) begin
                    erro_d = 1'b1;
                end
            end
        endcase

        redirect = (sel_pc != 2'b00);
        // A redirect always moves the PC, even while stalled.
        if (redirect) begin
            pc_d = alvo;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_mais4;
        end

        carrega  = 1'b0;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valido_d = valido_q;
        if (flush) begin
            instr_d  = 32'h0000_0000;
            pc4_d    = 32'h0000_0000;
            valido_d = 1'b0;
        end else if (!stall) begin
            instr_d  = instrucao_mem;
            pc4_d    = pc_mais4;
            valido_d = 1'b1;
            carrega  = 1'b1;
        end

        cont_d = carrega ? cont_q + 32'd1 : cont_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0000_0000;
            pc4_q    <= 32'h0000_0000;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            cont_q   <= 32'h0000_0000;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            cont_q   <= cont_d;
        end
    end

    assign pc_saida         = pc_q;
    assign if_id_instrucao  = instr_q;
    assign if_id_pc4        = pc4_q;
    assign if_id_valido     = valido_q;
    assign erro_alinhamento = erro_q;
    assign contador_busca   = cont_q;
    assign campo_jump       = {instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed self-checking bench for busca_instrucao.
// Memory is modelled as a simple function of the fetch address.
module tb_busca_instrucao;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  sel_pc;
    logic [31:0] desvio_offset;
    logic [31:0] endereco_jump;
    logic [31:0] registrador_jr;
    logic [31:0] instrucao_mem;
    logic [31:0] pc_saida;
    logic [31:0] if_id_instrucao;
    logic [31:0] if_id_pc4;
    logic        if_id_valido;
    logic [27:0] campo_jump;
    logic        erro_alinhamento;
    logic [31:0] contador_busca;

    int total = 0;
    int bad   = 0;
    logic [31:0] w;

    busca_instrucao #(.RESET_PC(RPC)) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .sel_pc(sel_pc),
        .desvio_offset(desvio_offset),
        .endereco_jump(endereco_jump),
        .registrador_jr(registrador_jr),
        .instrucao_mem(instrucao_mem),
        .pc_saida(pc_saida),
        .if_id_instrucao(if_id_instrucao),
        .if_id_pc4(if_id_pc4),
        .if_id_valido(if_id_valido),
        .campo_jump(campo_jump),
        .erro_alinhamento(erro_alinhamento),
        .contador_busca(contador_busca)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h2001_0005 + (a - RPC);
    endfunction

    assign instrucao_mem = mem(pc_saida);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; sel_pc = 2'b00;
        desvio_offset = '0; endereco_jump = '0; registrador_jr = '0;
        step(); step();
        total++;
        if (pc_saida !== RPC) begin
            bad++;
            $display("FAIL reset_pc got %h want %h", pc_saida, RPC);
        end
        total++;
        if ({if_id_valido, erro_alinhamento, contador_busca,
             if_id_instrucao, if_id_pc4} !== {2'b00, 96'h0}) begin
            bad++;
            $display("FAIL reset_state got v=%b e=%b c=%h i=%h p=%h want all 0",
                     if_id_valido, erro_alinhamento, contador_busca,
                     if_id_instrucao, if_id_pc4);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        step();
        total++;
        if ({pc_saida, if_id_pc4, if_id_instrucao, if_id_valido} !==
            {32'h0040_0004, 32'h0040_0004, 32'h2001_0005, 1'b1}) begin
            bad++;
            $display("FAIL seq_first got pc=%h p4=%h i=%h v=%b want 00400004 00400004 20010005 1",
                     pc_saida, if_id_pc4, if_id_instrucao, if_id_valido);
        end
        for (int k = 2; k <= 4; k++) begin
            step();
            total++;
            if (pc_saida !== RPC + 32'(4 * k)) begin
                bad++;
                $display("FAIL seq_pc%0d got %h want %h", k, pc_saida, RPC + 32'(4 * k));
            end
        end
        total++;
        if ({if_id_instrucao, if_id_pc4, contador_busca} !==
            {32'h2001_0011, 32'h0040_0010, 32'd4}) begin
            bad++;
            $display("FAIL seq_end got i=%h p4=%h c=%0d want 20010011 00400010 4",
                     if_id_instrucao, if_id_pc4, contador_busca);
        end
        total++;
        if (campo_jump !== 28'h004_0044) begin
            bad++;
            $display("FAIL campo_jump got %h want 0040044", campo_jump);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        step(); step();
        total++;
        if ({pc_saida, if_id_instrucao, contador_busca, if_id_valido} !==
            {32'h0040_0010, 32'h2001_0011, 32'd4, 1'b1}) begin
            bad++;
            $display("FAIL stall_hold got pc=%h i=%h c=%0d v=%b want 00400010 20010011 4 1",
                     pc_saida, if_id_instrucao, contador_busca, if_id_valido);
        end
        stall = 1'b0;
        step();
        total++;
        if ({pc_saida, if_id_instrucao, if_id_pc4, contador_busca} !==
            {32'h0040_0014, 32'h2001_0015, 32'h0040_0014, 32'd5}) begin
            bad++;
            $display("FAIL stall_resume got pc=%h i=%h p4=%h c=%0d want 00400014 20010015 00400014 5",
                     pc_saida, if_id_instrucao, if_id_pc4, contador_busca);
        end
    endtask

    task automatic test_jump();
        sel_pc = 2'b10; flush = 1'b1; endereco_jump = 32'hF000_0100;
        step();
        total++;
        if ({pc_saida, if_id_valido, if_id_instrucao, if_id_pc4, contador_busca} !==
            {32'h0000_0100, 1'b0, 32'h0, 32'h0, 32'd5}) begin
            bad++;
            $display("FAIL jump got pc=%h v=%b i=%h p4=%h c=%0d want 00000100 0 0 0 5",
                     pc_saida, if_id_valido, if_id_instrucao, if_id_pc4, contador_busca);
        end
        // pc4 is now 0, so this lands at 0x0040001C.
        endereco_jump = 32'h0040_001C;
        step();
        total++;
        if (pc_saida !== 32'h0040_001C) begin
            bad++;
            $display("FAIL jump2 got %h want 0040001c", pc_saida);
        end
        sel_pc = 2'b00; flush = 1'b0;
        step();
        total++;
        if ({pc_saida, if_id_pc4, contador_busca} !==
            {32'h0040_0020, 32'h0040_0020, 32'd6}) begin
            bad++;
            $display("FAIL after_jump got pc=%h p4=%h c=%0d want 00400020 00400020 6",
                     pc_saida, if_id_pc4, contador_busca);
        end
    endtask

    task automatic test_branch();
        sel_pc = 2'b01; stall = 1'b1; desvio_offset = 32'hFFFF_FFFC;
        step();
        total++;
        if (pc_saida !== 32'h0040_0010) begin
            bad++;
            $display("FAIL branch_back got %h want 00400010", pc_saida);
        end
        total++;
        if ({if_id_pc4, if_id_instrucao, contador_busca} !==
            {32'h0040_0020, 32'h2001_0021, 32'd6}) begin
            bad++;
            $display("FAIL branch_stall_ifid got p4=%h i=%h c=%0d want 00400020 20010021 6",
                     if_id_pc4, if_id_instrucao, contador_busca);
        end
        sel_pc = 2'b00; stall = 1'b0;
    endtask

    task automatic test_jr_wrap();
        sel_pc = 2'b11; flush = 1'b1; registrador_jr = 32'h0000_1002;
        step();
        total++;
        if ({pc_saida, erro_alinhamento, if_id_valido} !== {32'h0000_1000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL jr_misalign got pc=%h e=%b v=%b want 00001000 1 0",
                     pc_saida, erro_alinhamento, if_id_valido);
        end
        sel_pc = 2'b00; flush = 1'b0;
        step();
        w = mem(32'h0000_1000);
        total++;
        if ({pc_saida, erro_alinhamento, if_id_instrucao, contador_busca} !==
            {32'h0000_1004, 1'b1, w, 32'd7}) begin
            bad++;
            $display("FAIL jr_sticky got pc=%h e=%b i=%h c=%0d want 00001004 1 %h 7",
                     pc_saida, erro_alinhamento, if_id_instrucao, contador_busca, w);
        end
        sel_pc = 2'b11; flush = 1'b1; registrador_jr = 32'hFFFF_FFFC;
        step();
        total++;
        if (pc_saida !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL jr_top got %h want fffffffc", pc_saida);
        end
        sel_pc = 2'b00; flush = 1'b0;
        step();
        total++;
        if ({pc_saida, if_id_pc4, if_id_valido, erro_alinhamento, contador_busca} !==
            {32'h0, 32'h0, 1'b1, 1'b1, 32'd8}) begin
            bad++;
            $display("FAIL wrap got pc=%h p4=%h v=%b e=%b c=%0d want 0 0 1 1 8",
                     pc_saida, if_id_pc4, if_id_valido, erro_alinhamento, contador_busca);
        end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; flush = 1'b1;
        step();
        total++;
        if ({pc_saida, if_id_valido, if_id_instrucao, if_id_pc4, contador_busca} !==
            {32'h0, 1'b0, 32'h0, 32'h0, 32'd8}) begin
            bad++;
            $display("FAIL bubble got pc=%h v=%b i=%h p4=%h c=%0d want 0 0 0 0 8",
                     pc_saida, if_id_valido, if_id_instrucao, if_id_pc4, contador_busca);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        stall = 1'b1; sel_pc = 2'b10; endereco_jump = 32'h0000_0200; reset = 1'b1;
        step();
        total++;
        if ({pc_saida, erro_alinhamento, contador_busca, if_id_valido} !==
            {RPC, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got pc=%h e=%b c=%0d v=%b want 00400000 0 0 0",
                     pc_saida, erro_alinhamento, contador_busca, if_id_valido);
        end
        reset = 1'b0; stall = 1'b0; sel_pc = 2'b00;
        step();
        total++;
        if ({pc_saida, if_id_instrucao, contador_busca} !==
            {32'h0040_0004, 32'h2001_0005, 32'd1}) begin
            bad++;
            $display("FAIL reset_refetch got pc=%h i=%h c=%0d want 00400004 20010005 1",
                     pc_saida, if_id_instrucao, contador_busca);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch();
        test_jr_wrap();
        test_stall_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
